// File: rtl/add_arbiter_16bit.sv
// Two-requester add/sub unit: round-robin arbitration feeding one shared
// adder datapath. Each operation runs IDLE -> EXEC -> DONE and takes 3 cycles.
module add_arbiter_16bit #(
   parameter int unsigned WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req0,
   input  logic [WIDTH-1:0] a0,
   input  logic [WIDTH-1:0] b0,
   input  logic             sub0,
   input  logic             req1,
   input  logic [WIDTH-1:0] a1,
   input  logic [WIDTH-1:0] b1,
   input  logic             sub1,
   output logic             gnt0,
   output logic             gnt1,
   output logic             done0,
   output logic             done1,
   output logic [WIDTH-1:0] sum,
   output logic             c_out,
   output logic             ovf,
   output logic             busy
);

   typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

   state_t           state, state_nxt;
   logic             last_gnt;   // 1: requester 1 was granted most recently
   logic             owner;
   logic [WIDTH-1:0] op_a, op_b;
   logic             op_sub;
   logic             take, pick1;
   logic [WIDTH-1:0] b_eff;
   logic [WIDTH:0]   raw;
   logic             ovf_nxt;

   always_comb begin
      state_nxt = state;
      take      = 1'b0;
      pick1     = 1'b0;
      case (state)
         IDLE: begin
            if (req0 || req1) begin
               take      = 1'b1;
               pick1     = req1 && (!req0 || !last_gnt);
               state_nxt = EXEC;
            end
         end
         EXEC:    state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Subtraction is A + ~B + 1; overflow when both adder inputs share a sign
   // that the result does not.
   always_comb begin
      b_eff   = op_sub ? ~op_b : op_b;
      raw     = {1'b0, op_a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, op_sub};
      ovf_nxt = (op_a[WIDTH-1] == b_eff[WIDTH-1]) && (raw[WIDTH-1] != op_a[WIDTH-1]);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_gnt <= 1'b1;
         owner    <= 1'b0;
         op_a     <= '0;
         op_b     <= '0;
         op_sub   <= 1'b0;
         gnt0     <= 1'b0;
         gnt1     <= 1'b0;
         done0    <= 1'b0;
         done1    <= 1'b0;
         sum      <= '0;
         c_out    <= 1'b0;
         ovf      <= 1'b0;
      end else begin
         gnt0  <= take && !pick1;
         gnt1  <= take && pick1;
         done0 <= (state == DONE) && !owner;
         done1 <= (state == DONE) && owner;
         if (take) begin
            owner    <= pick1;
            last_gnt <= pick1;
            op_a     <= pick1 ? a1   : a0;
            op_b     <= pick1 ? b1   : b0;
            op_sub   <= pick1 ? sub1 : sub0;
         end
         if (state == EXEC) begin
            sum   <= raw[WIDTH-1:0];
            c_out <= raw[WIDTH];
            ovf   <= ovf_nxt;
         end
      end
   end

   assign busy = (state != IDLE);

endmodule

// File: doc/add_arbiter_16bit.md
ADD_ARBITER_16BIT -- requirements
Module: add_arbiter_16bit

Interface
REQ-001 SHALL have parameter: WIDTH, 16, operand/result width; all widths below are in terms of WIDTH.
REQ-002 SHALL have port: clk  input  1  single clock, all state updates on rising edge.
REQ-003 SHALL have port: rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port: req0  input  1  requester 0 operation request, level.
REQ-005 SHALL have port: a0, b0  input  WIDTH each  requester 0 operands.
REQ-006 SHALL have port: sub0  input  1  requester 0 op select: 1 = A-B, 0 = A+B.
REQ-007 SHALL have port: req1, a1, b1, sub1  input  1/WIDTH/WIDTH/1  requester 1, same meanings.
REQ-008 SHALL have port: gnt0, gnt1  output  1 each  registered one-cycle operand-accepted pulse.
REQ-009 SHALL have port: done0, done1  output  1 each  registered one-cycle result-valid pulse.
REQ-010 SHALL have port: sum  output  WIDTH  registered result, shared by both requesters.
REQ-011 SHALL have port: c_out  output  1  registered carry (add) / no-borrow (sub).
REQ-012 SHALL have port: ovf  output  1  registered two's-complement overflow flag.
REQ-013 SHALL have port: busy  output  1  high whenever state is not IDLE.

Function
REQ-014 SHALL implement FSM with states IDLE, EXEC, DONE; one shared add/sub datapath.
REQ-015 IDLE: if req0 or req1 sampled high at edge, SHALL capture winner's a, b, sub, go to EXEC, and assert that requester's gnt for the following cycle only.
REQ-016 IDLE with no request SHALL remain IDLE; gnt/done stay low.
REQ-017 Arbitration SHALL be round-robin: single requester always wins; with both requesting, the requester not granted last wins; last-grant pointer resets to "1 last" so req0 wins first contention.
REQ-018 EXEC: SHALL compute on captured operands, register sum/c_out/ovf, go to DONE.
REQ-019 DONE: SHALL assert done of the granted requester for exactly this cycle, then go to IDLE.
REQ-020 Latency: request sampled at edge N -> gnt high in cycle N..N+1, done high in cycle N+2..N+3 (two cycles after gnt's rising edge is one); throughput one op per 3 cycles.
REQ-021 Add: {c_out,sum} = A + B, (WIDTH+1)-bit unsigned sum.
REQ-022 Sub: {c_out,sum} = A + ~B + 1; c_out=1 iff A >= B unsigned.
REQ-023 ovf: add -> A,B same sign and sum sign differs; sub -> A,B differ in sign and sum sign differs from A.
REQ-024 sum/c_out/ovf SHALL hold value between operations; updated only on EXEC->DONE edge.
REQ-025 Requests arriving while busy SHALL be ignored (not queued); a req held high through DONE SHALL be treated as a new request at the next IDLE sample.
REQ-026 Operand changes after gnt SHALL NOT affect the in-flight result.
REQ-027 gnt0/gnt1 and done0/done1 SHALL never be high simultaneously.

Reset
REQ-028 rst_n low SHALL immediately force: state IDLE, gnt0/gnt1/done0/done1/busy = 0, sum = 0, c_out = 0, ovf = 0, last-grant pointer = 1.
REQ-029 Reset during EXEC or DONE SHALL abort the operation; no done pulse after reset release.
REQ-030 First request sampled on first rising edge after rst_n deasserts SHALL be accepted normally.

Verification
REQ-031 req0, a0=0x7FFF, b0=0x0001, sub0=0 -> gnt0 pulse, done0 two cycles later, sum=0x8000, c_out=0, ovf=1.
REQ-032 req1, a1=0x0000, b1=0x0001, sub1=1 -> done1, sum=0xFFFF, c_out=0, ovf=0; then a1=0x8000, b1=0x0001, sub1=1 -> sum=0x7FFF, c_out=1, ovf=1.
REQ-033 req0 and req1 held high continuously from reset -> grants alternate gnt0, gnt1, gnt0, ..., one grant every 3 cycles, each done matching its gnt.
REQ-034 0xFFFF + 0x0001 add -> sum=0x0000, c_out=1, ovf=0; 0x8000 + 0x8000 add -> sum=0x0000, c_out=1, ovf=1.
REQ-035 rst_n pulsed low during EXEC -> outputs zero immediately, no done pulse, next request completes correctly.
REQ-036 req1 pulsed while busy with req0 op -> ignored; no gnt1 and no done1.
